// File: rtl/line_fill_buffer.sv
// Purpose: assembles one cache line from a run of memory read beats after a miss.
// Latency: start -> request next cycle; line_valid one cycle after the last beat (66 cycles minimum).
// Backpressure: none toward memory; mem_valid low simply stalls, fill_start is dropped while busy.
//
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   fill_start/fill_addr  start a line fill (accepted only when idle) for a line address
//   fill_abort            cancel an outstanding request or partial fill
//   mem_req/mem_addr      read request and line-aligned byte address toward memory
//   mem_ack               memory accepted the request
//   mem_valid/mem_data    incoming beat, ascending address order
//   line/line_addr        assembled line and its address (hold until the next accepted fill)
//   line_valid            one-cycle pulse when the line is complete
//   busy                  request, fill or completion in progress
//   beat_cnt              index of the next beat to be written
module line_fill_buffer #(
  parameter int LINE_BITS   = 2048,
  parameter int BEAT_BITS   = 32,
  parameter int ADDR_BITS   = 32,
  parameter int OFFSET_BITS = 8,
  localparam int BEATS      = LINE_BITS / BEAT_BITS,
  localparam int CNT_BITS   = $clog2(BEATS),
  localparam int LADDR_BITS = ADDR_BITS - OFFSET_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fill_start,
  input  logic [LADDR_BITS-1:0] fill_addr,
  input  logic                  fill_abort,
  output logic                  mem_req,
  output logic [ADDR_BITS-1:0]  mem_addr,
  input  logic                  mem_ack,
  input  logic                  mem_valid,
  input  logic [BEAT_BITS-1:0]  mem_data,
  output logic [LINE_BITS-1:0]  line,
  output logic [LADDR_BITS-1:0] line_addr,
  output logic                  line_valid,
  output logic                  busy,
  output logic [CNT_BITS-1:0]   beat_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic accept;     // fill_start taken this cycle
  logic cancel;     // abort of a live request or fill
  logic beat_wr;    // beat written into the line this cycle
  logic last_beat;  // current beat completes the line

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    cancel    = 1'b0;
    beat_wr   = 1'b0;
    last_beat = 1'b0;
    case (state)
      IDLE: begin
        if (fill_start) begin
          accept    = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        // Abort takes priority over a simultaneous acknowledge.
        if (fill_abort) begin
          cancel    = 1'b1;
          state_nxt = IDLE;
        end else if (mem_ack) begin
          state_nxt = FILL;
        end
      end
      FILL: begin
        // Abort also wins over the final beat: the line is never reported.
        if (fill_abort) begin
          cancel    = 1'b1;
          state_nxt = IDLE;
        end else if (mem_valid) begin
          beat_wr   = 1'b1;
          last_beat = (beat_cnt == CNT_BITS'(BEATS - 1));
          if (last_beat) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Control outputs are registered copies of the next state so that they
  // line up with the state they describe without any output decode logic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      line_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      mem_req    <= (state_nxt == REQ);
      line_valid <= (state_nxt == DONE);
      busy       <= (state_nxt != IDLE);
    end
  end

  // Address capture happens only on an accepted start, so both addresses
  // hold through REQ/FILL and keep describing the last fill once idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr  <= '0;
      line_addr <= '0;
    end else if (accept) begin
      mem_addr  <= {fill_addr, {OFFSET_BITS{1'b0}}};
      line_addr <= fill_addr;
    end
  end

  // beat_cnt is a power-of-two counter, so the increment after the last
  // beat naturally wraps it back to zero for the next fill.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt <= '0;
    end else if (accept || cancel) begin
      beat_cnt <= '0;
    end else if (beat_wr) begin
      beat_cnt <= beat_cnt + CNT_BITS'(1);
    end
  end

  // Beat k lands at bits [k*BEAT_BITS +: BEAT_BITS], which puts byte b of the
  // line at line[8b+7:8b]. Partial data is left in place on abort; consumers
  // only trust the line while line_valid is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line <= '0;
    end else if (beat_wr) begin
      line[int'(beat_cnt) * BEAT_BITS +: BEAT_BITS] <= mem_data;
    end
  end

endmodule

// File: doc/line_fill_buffer.md
Name: line_fill_buffer

Overview:
- Assembles one 2048-bit cache line from main memory as a sequence of 32-bit beats on a cache miss.
- Presents the completed line, with its line address, to the cache data array and the downstream byte-select stage.
- Sits between the memory read port and the direct-mapped cache; the controller starts it on a miss.
- Byte b of the line lands at line[8b+7:8b], which matches the byte-select ordering.

Parameters:
- LINE_BITS, 2048, line width in bits.
- BEAT_BITS, 32, memory beat width in bits. LINE_BITS/BEAT_BITS must be a power of 2.
- ADDR_BITS, 32, physical byte address width.
- OFFSET_BITS, 8, block-offset bits (log2 of bytes per line).
- Derived: BEATS = LINE_BITS/BEAT_BITS (64); CNT_BITS = log2(BEATS) (6); LADDR_BITS = ADDR_BITS-OFFSET_BITS (24).

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- fill_start  in  1  single-cycle request to fill a line; accepted only in IDLE.
- fill_addr  in  LADDR_BITS  line address (tag 16 + index 8), sampled when fill_start is accepted.
- fill_abort  in  1  cancels the fill in progress.
- mem_req  out  1  read request to memory.
- mem_addr  out  ADDR_BITS  byte address of the line, {fill_addr, OFFSET_BITS'b0}.
- mem_ack  in  1  memory has accepted the request.
- mem_valid  in  1  mem_data carries a valid beat this cycle.
- mem_data  in  BEAT_BITS  read beat, in ascending address order.
- line  out  LINE_BITS  line under assembly / completed line.
- line_addr  out  LADDR_BITS  address of the line being filled or last filled.
- line_valid  out  1  one-cycle pulse: line is complete and consistent.
- busy  out  1  high in REQ, FILL and DONE.
- beat_cnt  out  CNT_BITS  index of the next beat to be written.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; mem_req=0; mem_addr=0; line=0; line_addr=0; line_valid=0; busy=0; beat_cnt=0. Reset mid-fill discards all partial data immediately.
- States: IDLE, REQ, FILL, DONE. All outputs are registered.
- IDLE:
  - fill_start=1 → REQ next cycle.
  - Capture line_addr=fill_addr and mem_addr={fill_addr,8'h00]; set beat_cnt=0.
  - fill_start is ignored in every other state; no queueing.
- REQ:
  - mem_req=1; mem_addr is held stable.
  - mem_ack=1 → FILL next cycle, mem_req drops to 0.
  - mem_valid in REQ is ignored.
- FILL:
  - Each cycle with mem_valid=1 writes line[beat_cnt*BEAT_BITS +: BEAT_BITS] = mem_data and increments beat_cnt.
  - mem_valid=0 is a stall with no change; gaps between beats are allowed.
  - mem_valid=1 with beat_cnt=BEATS-1 writes the last beat, wraps beat_cnt to 0 and moves to DONE.
- DONE: line_valid=1 for exactly one cycle, then IDLE. line and line_addr hold until the next accepted fill_start.
- Consumers must sample line only on line_valid. Words written during FILL are visible early but carry no guarantee.
- Abort:
  - fill_abort=1 in REQ or FILL → IDLE next cycle; mem_req=0; beat_cnt=0; no line_valid.
  - Abort beats a simultaneous mem_ack or last beat.
  - Abort in IDLE or DONE has no effect; DONE still pulses line_valid.
- Beats arriving in IDLE or DONE are dropped.
- Minimum latency with back-to-back beats:
  - start at t0, REQ at t1 with mem_ack, beats t2..t65, line_valid at t66.

Test Plan:
- Reset mid-FILL (after 10 beats) → all outputs 0 on the same edge as reset assertion. After release, a fresh fill completes normally.
- Basic fill:
  - Stimulus: fill_addr=24'hABCD12; mem_ack on the first REQ cycle; beat k = 32'h0100_0000+k, back to back.
  - Required: mem_addr=32'hABCD1200; line_valid exactly at t0+66; line[31:0]=32'h01000000; line[2047:2016]=32'h0100003F; line_addr=24'hABCD12.
  - Byte check: byte offset 8'hFD reads 8'h00; offset 8'hFC reads 8'h3F.
- Stalls: mem_ack delayed 3 cycles; mem_valid toggled 1,0,1,0 → mem_req stays high through the wait. line_valid after the 64th valid beat; content identical to the basic fill.
- Abort with last beat: fill_abort asserted in the cycle of beat 63 → no line_valid, state IDLE, beat_cnt=0. A new fill_start the next cycle is accepted.
- Ignored inputs: fill_start pulsed in FILL and DONE; mem_valid driven in REQ and IDLE → no effect on line_addr, beat_cnt or line.
